// File: rtl/exp_pkg.sv
// Shared types and elaboration-time helpers for the e^-x pipeline:
// pipeline flags, group geometry and the per-bit constant table generator.
package exp_pkg;

  typedef struct packed {
    logic one;
    logic zero;
    logic ovf;
  } exp_flags_t;

  function automatic int exp_n(input int int_w, input int frac_w);
    return int_w + frac_w;
  endfunction

  function automatic int exp_stages(input int n, input int bps);
    return (n + bps - 1) / bps;
  endfunction

  // Groups are cut from the MSB down, so only the final (lowest) group can be narrow.
  function automatic int grp_hi(input int g, input int n, input int bps);
    return n - 1 - g * bps;
  endfunction

  function automatic int grp_lo(input int g, input int n, input int bps);
    int lo;
    lo = grp_hi(g, n, bps) - bps + 1;
    return (lo < 0) ? 0 : lo;
  endfunction

  // floor(e^-(2^(p-frac_w)) * 2^out_w), clamped to the output range.
  // e^y is summed as a positive-term series and inverted to keep precision at large y.
  function automatic logic [63:0] exp_lut(input int p, input int frac_w, input int out_w);
    real y;
    real term;
    real sum;
    real scaled;
    logic [63:0] val;
    logic [63:0] max_val;
    y = 1.0;
    for (int i = 0; i < p - frac_w; i++) y = y * 2.0;
    for (int i = 0; i < frac_w - p; i++) y = y / 2.0;
    term = 1.0;
    sum  = 1.0;
    for (int k = 1; k < 100; k++) begin
      term = term * y / k;
      sum  = sum + term;
    end
    scaled = 1.0;
    for (int i = 0; i < out_w; i++) scaled = scaled * 2.0;
    scaled  = scaled / sum;
    val     = 64'($rtoi(scaled));
    max_val = (64'd1 << out_w) - 64'd1;
    if (val > max_val) val = max_val;
    return val;
  endfunction

endpackage

// File: rtl/exp_mul_stage.sv
// One multiply stage: folds the constants for its bit group of x into the
// running product, then registers product, flags, x and tag under the global enable.
module exp_mul_stage
  import exp_pkg::*;
#(
  parameter int GROUP          = 0,
  parameter int BITS_PER_STAGE = 2,
  parameter int OUT_W          = 16,
  parameter int FRAC_W         = 16,
  parameter int N_BITS         = 20,
  parameter int TAG_W          = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic [N_BITS-1:0] x_i,
  input  exp_flags_t        flags_i,
  input  logic [OUT_W-1:0]  acc_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              valid_o,
  output logic [N_BITS-1:0] x_o,
  output exp_flags_t        flags_o,
  output logic [OUT_W-1:0]  acc_o,
  output logic [TAG_W-1:0]  tag_o
);

  localparam int HI = grp_hi(GROUP, N_BITS, BITS_PER_STAGE);
  localparam int LO = grp_lo(GROUP, N_BITS, BITS_PER_STAGE);
  localparam int GW = HI - LO + 1;

  logic [GW-1:0][OUT_W-1:0] lut;
  logic [GW-1:0]            bits;

  for (genvar i = 0; i < GW; i++) begin : g_lut
    localparam logic [OUT_W-1:0] LUT_V = OUT_W'(exp_lut(LO + i, FRAC_W, OUT_W));
    assign lut[i] = LUT_V;
  end

  assign bits = x_i[HI:LO];

  logic               valid_d, valid_q;
  logic [N_BITS-1:0]  x_d, x_q;
  exp_flags_t         flags_d, flags_q;
  logic [OUT_W-1:0]   acc_d, acc_q;
  logic [TAG_W-1:0]   tag_d, tag_q;
  logic               one_d;
  logic [2*OUT_W-1:0] prod;

  // Bits are folded highest first; the first set bit loads its constant instead of multiplying by 1.0.
  always_comb begin
    valid_d = valid_i;
    x_d     = x_i;
    tag_d   = tag_i;
    acc_d   = acc_i;
    one_d   = flags_i.one;
    prod    = '0;
    for (int i = GW - 1; i >= 0; i--) begin
      if (bits[i]) begin
        prod = {{OUT_W{1'b0}}, acc_d} * {{OUT_W{1'b0}}, lut[i]};
        if (one_d) acc_d = lut[i];
        else       acc_d = prod[2*OUT_W-1:OUT_W];
        one_d = 1'b0;
      end
    end
    flags_d     = flags_i;
    flags_d.one = one_d;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      x_q     <= '0;
      flags_q <= '0;
      acc_q   <= '0;
      tag_q   <= '0;
    end else if (en_i) begin
      valid_q <= valid_d;
      x_q     <= x_d;
      flags_q <= flags_d;
      acc_q   <= acc_d;
      tag_q   <= tag_d;
    end
  end

  assign valid_o = valid_q;
  assign x_o     = x_q;
  assign flags_o = flags_q;
  assign acc_o   = acc_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/exp_pipe.sv
// Pipelined e^-x for the softmax compute path: input register, one multiply
// stage per bit group, output register; a single global enable gives full backpressure.
module exp_pipe
  import exp_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int FRAC_W         = 16,
  parameter int INT_W          = 4,
  parameter int OUT_W          = 16,
  parameter int BITS_PER_STAGE = 2,
  parameter int TAG_W          = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [TAG_W-1:0]  in_tag_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [OUT_W-1:0]  out_data_o,
  output logic [TAG_W-1:0]  out_tag_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);

  localparam int N = exp_n(INT_W, FRAC_W);
  localparam int S = exp_stages(N, BITS_PER_STAGE);

  logic stall;
  logic en;
  logic in_ovf;

  logic             s0_valid_d, s0_valid_q;
  logic [N-1:0]     s0_x_d, s0_x_q;
  exp_flags_t       s0_flags_d, s0_flags_q;
  logic [TAG_W-1:0] s0_tag_d, s0_tag_q;

  logic [S:0]            st_valid;
  logic [S:0][N-1:0]     st_x;
  exp_flags_t [S:0]      st_flags;
  logic [S:0][OUT_W-1:0] st_acc;
  logic [S:0][TAG_W-1:0] st_tag;

  logic             out_valid_d, out_valid_q;
  logic [OUT_W-1:0] out_data_d, out_data_q;
  logic [TAG_W-1:0] out_tag_d, out_tag_q;

  // Every register shares one enable, so a stalled output freezes the whole pipe without squeezing bubbles.
  assign stall      = out_valid_q & ~out_ready_i;
  assign en         = ~stall;
  assign in_ready_o = en;

  if (DATA_W > N) begin : g_ovf
    assign in_ovf = |in_data_i[DATA_W-1:N];
  end else begin : g_no_ovf
    assign in_ovf = 1'b0;
  end

  always_comb begin
    s0_valid_d      = in_valid_i;
    s0_x_d          = in_data_i[N-1:0];
    s0_tag_d        = in_tag_i;
    s0_flags_d.one  = 1'b1;
    s0_flags_d.zero = (in_data_i == '0);
    s0_flags_d.ovf  = in_ovf;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      s0_valid_q <= 1'b0;
      s0_x_q     <= '0;
      s0_flags_q <= '0;
      s0_tag_q   <= '0;
    end else if (en) begin
      s0_valid_q <= s0_valid_d;
      s0_x_q     <= s0_x_d;
      s0_flags_q <= s0_flags_d;
      s0_tag_q   <= s0_tag_d;
    end
  end

  assign st_valid[0] = s0_valid_q;
  assign st_x[0]     = s0_x_q;
  assign st_flags[0] = s0_flags_q;
  assign st_acc[0]   = '0;
  assign st_tag[0]   = s0_tag_q;

  for (genvar g = 0; g < S; g++) begin : g_stage
    exp_mul_stage #(
      .GROUP          (g),
      .BITS_PER_STAGE (BITS_PER_STAGE),
      .OUT_W          (OUT_W),
      .FRAC_W         (FRAC_W),
      .N_BITS         (N),
      .TAG_W          (TAG_W)
    ) u_stage (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .en_i    (en),
      .valid_i (st_valid[g]),
      .x_i     (st_x[g]),
      .flags_i (st_flags[g]),
      .acc_i   (st_acc[g]),
      .tag_i   (st_tag[g]),
      .valid_o (st_valid[g+1]),
      .x_o     (st_x[g+1]),
      .flags_o (st_flags[g+1]),
      .acc_o   (st_acc[g+1]),
      .tag_o   (st_tag[g+1])
    );
  end

  // Out-of-range inputs saturate to 0 ahead of everything; x==0 never multiplied, so it maps to full scale.
  always_comb begin
    out_valid_d = st_valid[S];
    out_tag_d   = st_tag[S];
    if (st_flags[S].ovf)       out_data_d = '0;
    else if (st_flags[S].zero) out_data_d = '1;
    else                       out_data_d = st_acc[S];
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else if (en) begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
    end
  end

  logic unused_tail;
  assign unused_tail = ^{st_x[S], st_flags[S].one};

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_tag_o   = out_tag_q;

endmodule

// File: tb/tb_exp_pipe.sv
// Self-checking bench for exp_pipe: directed vectors with hand-computed results,
// streaming with and without backpressure, mid-stream reset, and two parameter variants.
module tb_exp_pipe;

   logic        clock_i = 1'b0;
   logic        reset_i;
   logic [31:0] in_data_i;
   logic [7:0]  in_tag_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [15:0] out_data_o;
   logic [7:0]  out_tag_o;
   logic        out_valid_o;
   logic        out_ready_i;

   logic [31:0] sw_data;
   logic [7:0]  sw_tag;
   logic        sw_valid;
   logic        b1_ready, b1_valid, b3_ready, b3_valid;
   logic [15:0] b1_data;
   logic [23:0] b3_data;
   logic [7:0]  b1_tag, b3_tag;

   int errors = 0;
   int checks = 0;
   int pushes = 0;
   int pops   = 0;
   int cyc    = 0;

   logic [15:0] sb_data [$];
   logic [7:0]  sb_tag [$];
   int          pop_cyc [$];

   logic        prev_stall = 1'b0;
   logic [15:0] prev_data  = '0;
   logic [7:0]  prev_tag   = '0;

   exp_pipe dut (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .in_data_i   (in_data_i),
      .in_tag_i    (in_tag_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .out_data_o  (out_data_o),
      .out_tag_o   (out_tag_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i)
   );

   exp_pipe #(.BITS_PER_STAGE(1)) dut_b1 (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .in_data_i   (sw_data),
      .in_tag_i    (sw_tag),
      .in_valid_i  (sw_valid),
      .in_ready_o  (b1_ready),
      .out_data_o  (b1_data),
      .out_tag_o   (b1_tag),
      .out_valid_o (b1_valid),
      .out_ready_i (1'b1)
   );

   exp_pipe #(.BITS_PER_STAGE(3), .OUT_W(24)) dut_b3 (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .in_data_i   (sw_data),
      .in_tag_i    (sw_tag),
      .in_valid_i  (sw_valid),
      .in_ready_o  (b3_ready),
      .out_data_o  (b3_data),
      .out_tag_o   (b3_tag),
      .out_valid_o (b3_valid),
      .out_ready_i (1'b1)
   );

   always #5 clock_i = ~clock_i;

   always @(posedge clock_i) cyc <= cyc + 1;

   // Counts one comparison and reports it when the observed value differs.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Reference e^-x for INT_W=4, FRAC_W=16, DATA_W=32 with constants taken from $exp.
   function automatic logic [63:0] refExp(input logic [31:0] x, input int ow);
      logic [63:0] acc;
      logic [63:0] lut;
      logic [63:0] maxv;
      bit          one;
      real         v;
      maxv = (64'd1 << ow) - 64'd1;
      if (x == 32'd0) return maxv;
      if (x[31:20] != 12'd0) return 64'd0;
      one = 1'b1;
      acc = 64'd0;
      for (int p = 19; p >= 0; p--) begin
         if (x[p]) begin
            v   = $exp(-$pow(2.0, p - 16)) * $pow(2.0, ow);
            lut = 64'($rtoi($floor(v)));
            if (lut > maxv) lut = maxv;
            if (one) begin
               acc = lut;
               one = 1'b0;
            end else begin
               acc = (acc * lut) >> ow;
            end
         end
      end
      return acc;
   endfunction

   // Scoreboard, hold-while-stalled and ready-equation checks, sampled mid-cycle.
   always @(negedge clock_i) begin
      logic [63:0] r;
      if (reset_i) begin
         sb_data.delete();
         sb_tag.delete();
         prev_stall = 1'b0;
      end else begin
         checkOutput("in_ready_eq", in_ready_o, !(out_valid_o && !out_ready_i));
         if (prev_stall) begin
            checkOutput("hold_data", out_data_o, prev_data);
            checkOutput("hold_tag", out_tag_o, prev_tag);
         end
         if (out_valid_o && out_ready_i) begin
            pops++;
            pop_cyc.push_back(cyc);
            checkOutput("sb_nonempty", sb_data.size() > 0, 1);
            if (sb_data.size() > 0) begin
               checkOutput("sb_data", out_data_o, sb_data.pop_front());
               checkOutput("sb_tag", out_tag_o, sb_tag.pop_front());
            end
         end
         if (in_valid_i && in_ready_o) begin
            r = refExp(in_data_i, 16);
            sb_data.push_back(r[15:0]);
            sb_tag.push_back(in_tag_i);
            pushes++;
         end
         prev_stall = out_valid_o && !out_ready_i;
         prev_data  = out_data_o;
         prev_tag   = out_tag_o;
      end
   end

   // Sends one beat to all three pipes and checks latency, data and tag of each.
   task automatic applyStimulus(input logic [31:0] x, input logic [7:0] tag, input logic [15:0] exp16);
      int          lat_m, lat_1, lat_3;
      logic [15:0] d_m, d_1;
      logic [23:0] d_3;
      logic [7:0]  t_m, t_1, t_3;
      logic [63:0] r3;
      lat_m = -1; lat_1 = -1; lat_3 = -1;
      d_m = '0; d_1 = '0; d_3 = '0; t_m = '0; t_1 = '0; t_3 = '0;
      r3 = refExp(x, 24);
      out_ready_i = 1'b1;
      @(posedge clock_i); #1;
      in_data_i = x; in_tag_i = tag; in_valid_i = 1'b1;
      sw_data = x; sw_tag = tag; sw_valid = 1'b1;
      @(posedge clock_i); #1;
      in_valid_i = 1'b0;
      sw_valid = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clock_i); #1;
         if (lat_m < 0 && out_valid_o) begin lat_m = k; d_m = out_data_o; t_m = out_tag_o; end
         if (lat_1 < 0 && b1_valid) begin lat_1 = k; d_1 = b1_data; t_1 = b1_tag; end
         if (lat_3 < 0 && b3_valid) begin lat_3 = k; d_3 = b3_data; t_3 = b3_tag; end
         if (lat_m >= 0 && lat_1 >= 0 && lat_3 >= 0) break;
      end
      checkOutput($sformatf("lat_x%0h", x), lat_m, (20 + 2 - 1) / 2 + 1);
      checkOutput($sformatf("data_x%0h", x), d_m, exp16);
      checkOutput($sformatf("tag_x%0h", x), t_m, tag);
      checkOutput($sformatf("b1_lat_x%0h", x), lat_1, 20 + 1);
      checkOutput($sformatf("b1_data_x%0h", x), d_1, exp16);
      checkOutput($sformatf("b1_tag_x%0h", x), t_1, tag);
      checkOutput($sformatf("b3_lat_x%0h", x), lat_3, (20 + 3 - 1) / 3 + 1);
      checkOutput($sformatf("b3_data_x%0h", x), d_3, r3);
      checkOutput($sformatf("b3_tag_x%0h", x), t_3, tag);
   endtask

   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      out_ready_i = 1'b1;
      while ((sb_data.size() != 0 || out_valid_o) && n < budget) begin
         @(posedge clock_i); #1;
         n++;
      end
      checkOutput("drain_pending", sb_data.size(), 0);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: time limit reached, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          base;
      int          pbase;
      int          idx;
      int          guard;
      logic        accepted;
      logic [31:0] sx;

      reset_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0; in_tag_i = '0; out_ready_i = 1'b1;
      sw_valid = 1'b0; sw_data = '0; sw_tag = '0;
      repeat (3) @(posedge clock_i);
      #1;
      checkOutput("rst_out_valid", out_valid_o, 0);
      checkOutput("rst_out_data", out_data_o, 0);
      checkOutput("rst_out_tag", out_tag_o, 0);
      reset_i = 1'b0;
      #1;
      checkOutput("rst_in_ready", in_ready_o, 1);

      applyStimulus(32'h0000_0000, 8'hA5, 16'hFFFF);
      applyStimulus(32'h0001_0000, 8'h01, 16'h5E2D);
      applyStimulus(32'h0002_0000, 8'h02, 16'h22A5);
      applyStimulus(32'h0000_8000, 8'h03, 16'h9B45);
      applyStimulus(32'h0001_8000, 8'h04, 16'h391E);
      applyStimulus(32'h0010_0000, 8'h05, 16'h0000);
      applyStimulus(32'h8000_0000, 8'h06, 16'h0000);
      applyStimulus(32'h000F_FFFF, 8'h07, 16'(refExp(32'h000F_FFFF, 16)));

      $display("[TB] back-to-back stream of 32 beats");
      base = pops;
      out_ready_i = 1'b1;
      @(posedge clock_i); #1;
      for (int i = 0; i < 32; i++) begin
         case (i % 6)
            0:       sx = 32'h0000_0000;
            1:       sx = 32'h0010_0000 << (i % 4);
            default: sx = {12'h000, 20'($urandom)};
         endcase
         in_valid_i = 1'b1; in_tag_i = 8'(i); in_data_i = sx;
         @(posedge clock_i); #1;
      end
      in_valid_i = 1'b0;
      waitDrain(200);
      checkOutput("stream_count", pops - base, 32);
      if (pops - base >= 32) checkOutput("stream_span", pop_cyc[base + 31] - pop_cyc[base], 31);

      $display("[TB] random backpressure stream");
      base = pops;
      pbase = pushes;
      idx = 0;
      guard = 0;
      @(posedge clock_i); #1;
      while (idx < 40 && guard < 2000) begin
         out_ready_i = 1'($urandom_range(0, 1));
         in_valid_i = 1'b1;
         in_tag_i = 8'(idx + 64);
         in_data_i = {12'h000, 20'($urandom)};
         #1;
         accepted = in_ready_o;
         @(posedge clock_i); #1;
         if (accepted) idx++;
         guard++;
      end
      in_valid_i = 1'b0;
      waitDrain(400);
      checkOutput("bp_accepted", idx, 40);
      checkOutput("bp_pushes", pushes - pbase, 40);
      checkOutput("bp_pops", pops - base, 40);

      $display("[TB] reset with beats in flight");
      out_ready_i = 1'b0;
      @(posedge clock_i); #1;
      for (int i = 0; i < 5; i++) begin
         in_valid_i = 1'b1; in_tag_i = 8'(i + 128); in_data_i = 32'h0000_4000 << i;
         @(posedge clock_i); #1;
      end
      in_valid_i = 1'b0;
      repeat (14) @(posedge clock_i);
      #2;
      checkOutput("pre_rst_valid", out_valid_o, 1);
      reset_i = 1'b1;
      #1;
      checkOutput("async_rst_valid", out_valid_o, 0);
      checkOutput("async_rst_data", out_data_o, 0);
      @(posedge clock_i); #1;
      reset_i = 1'b0;
      out_ready_i = 1'b1;
      base = pops;
      applyStimulus(32'h0002_0000, 8'h77, 16'h22A5);
      repeat (25) @(posedge clock_i);
      #1;
      checkOutput("post_rst_pops", pops - base, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
